// File: rtl/i2s_pcm_packer_if.sv
// i2s_pcm_packer_if
// Groups the two data paths of the PCM packer: the show-ahead read port of
// the I2S RX sample FIFO and the packed-word valid/ready output stream.
//   fifo_empty  FIFO has no entries
//   fifo_rdata  FIFO head entry (valid while fifo_empty is low)
//   fifo_rd     pop strobe from the packer
//   out_valid   packed word available
//   out_ready   consumer accepts the word
//   out_data    packed word, sample 0 in the lowest lane
//   out_lanes   number of valid lanes in out_data
// master = packer side, slave = FIFO/consumer side.
interface i2s_pcm_packer_if;
   logic        fifo_empty;
   logic [31:0] fifo_rdata;
   logic        fifo_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_lanes;

   modport master (
      input  fifo_empty, fifo_rdata, out_ready,
      output fifo_rd, out_valid, out_data, out_lanes
   );

   modport slave (
      output fifo_empty, fifo_rdata, out_ready,
      input  fifo_rd, out_valid, out_data, out_lanes
   );
endinterface

// File: rtl/i2s_pcm_packer.sv
// i2s_pcm_packer
// Pops PCM samples from the I2S RX FIFO and packs 1x32, 2x16 or 4x8-bit
// samples into 32-bit words on a valid/ready stream. A partial word is
// emitted on a flush pulse or after a programmable idle timeout.
// Ports:
//   clk        system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   en         packer enable; mode is latched when it rises
//   pack_mode  00 1x32, 01 2x16, 10 4x8, 11 treated as 00
//   timeout    idle cycles before a partial word is flushed (0 = off)
//   flush      single-cycle request to emit the partial word
//   bus        FIFO read port + packed output stream (master modport)
//   words_out  count of accepted output words, wraps at 16 bits
module i2s_pcm_packer #(
   parameter int TW = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [1:0]             pack_mode,
   input  logic [TW-1:0]          timeout,
   input  logic                   flush,
   i2s_pcm_packer_if.master       bus,
   output logic [15:0]            words_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_r;
   logic [1:0]    mode_r;
   logic [31:0]   acc_r;
   logic [1:0]    lane_cnt_r;
   logic [TW-1:0] idle_ctr_r;
   logic          out_valid_r;
   logic [31:0]   out_data_r;
   logic [2:0]    out_lanes_r;
   logic [15:0]   words_out_r;

   logic [1:0]    last_lane_s;
   logic [2:0]    lanes_n_s;
   logic          slot_free_s;
   logic          pop_s;
   logic          complete_s;
   logic          timeout_hit_s;
   logic          trigger_s;
   logic          drain_emit_s;
   logic          load_s;
   logic [31:0]   merged_s;

   // Write the sample into one lane of the accumulator, keeping the others.
   function automatic logic [31:0] insert_lane(
      input logic [31:0] acc,
      input logic [31:0] smp,
      input logic [1:0]  mode,
      input logic [1:0]  lane
   );
      logic [31:0] r;
      r = acc;
      case (mode)
         2'b01: begin
            if (lane[0]) begin
               r[31:16] = smp[15:0];
            end else begin
               r[15:0] = smp[15:0];
            end
         end
         2'b10: begin
            case (lane)
               2'd0:    r[7:0]   = smp[7:0];
               2'd1:    r[15:8]  = smp[7:0];
               2'd2:    r[23:16] = smp[7:0];
               default: r[31:24] = smp[7:0];
            endcase
         end
         default: r = smp;
      endcase
      return r;
   endfunction

   // Lanes per word for the latched mode.
   always_comb begin
      last_lane_s = 2'd0;
      lanes_n_s   = 3'd1;
      case (mode_r)
         2'b01: begin
            last_lane_s = 2'd1;
            lanes_n_s   = 3'd2;
         end
         2'b10: begin
            last_lane_s = 2'd3;
            lanes_n_s   = 3'd4;
         end
         default: begin
            last_lane_s = 2'd0;
            lanes_n_s   = 3'd1;
         end
      endcase
   end

   assign slot_free_s = !out_valid_r || bus.out_ready;

   // Pop decision: a sample that completes a word is only taken when the
   // output slot can accept the word in the same cycle.
   always_comb begin
      if ((state_r == ST_RUN) && en && !bus.fifo_empty &&
          ((lane_cnt_r < last_lane_s) || slot_free_s)) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   assign complete_s    = pop_s && (lane_cnt_r == last_lane_s);
   assign merged_s      = insert_lane(acc_r, bus.fifo_rdata, mode_r, lane_cnt_r);
   assign timeout_hit_s = (timeout != {TW{1'b0}}) && (idle_ctr_r == timeout);
   // A completing pop leaves nothing to flush, so it wins over a trigger.
   assign trigger_s     = (flush || timeout_hit_s) && (lane_cnt_r != 2'd0) && !complete_s;
   assign drain_emit_s  = (state_r == ST_DRAIN) && en && slot_free_s;
   assign load_s        = complete_s || drain_emit_s;

   // Packer FSM with accumulator, idle counter and registered output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mode_r      <= 2'b00;
         acc_r       <= 32'd0;
         lane_cnt_r  <= 2'd0;
         idle_ctr_r  <= {TW{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= 32'd0;
         out_lanes_r <= 3'd0;
      end else begin
         // A pending word is never retracted; it only drops once accepted,
         // unless a new word replaces it in the same cycle.
         if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= complete_s ? merged_s : acc_r;
            out_lanes_r <= complete_s ? lanes_n_s : {1'b0, lane_cnt_r};
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end

         if (!en) begin
            state_r    <= ST_IDLE;
            acc_r      <= 32'd0;
            lane_cnt_r <= 2'd0;
            idle_ctr_r <= {TW{1'b0}};
         end else begin
            case (state_r)
               ST_IDLE: begin
                  mode_r  <= (pack_mode == 2'b11) ? 2'b00 : pack_mode;
                  state_r <= ST_RUN;
               end
               ST_RUN: begin
                  if (pop_s) begin
                     if (complete_s) begin
                        acc_r      <= 32'd0;
                        lane_cnt_r <= 2'd0;
                        idle_ctr_r <= {TW{1'b0}};
                     end else begin
                        acc_r      <= merged_s;
                        lane_cnt_r <= lane_cnt_r + 2'd1;
                        // The pop cycle counts as idle cycle 0, so the
                        // counter reads 1 in the first cycle after it.
                        idle_ctr_r <= TW'(1);
                     end
                  end else if (lane_cnt_r == 2'd0) begin
                     idle_ctr_r <= {TW{1'b0}};
                  end else if (idle_ctr_r != {TW{1'b1}}) begin
                     idle_ctr_r <= idle_ctr_r + TW'(1);
                  end else begin
                     idle_ctr_r <= idle_ctr_r;
                  end
                  if (trigger_s) begin
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
               ST_DRAIN: begin
                  if (slot_free_s) begin
                     acc_r      <= 32'd0;
                     lane_cnt_r <= 2'd0;
                     idle_ctr_r <= {TW{1'b0}};
                     state_r    <= ST_RUN;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Accepted-word counter, running regardless of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_out_r <= 16'd0;
      end else if (out_valid_r && bus.out_ready) begin
         words_out_r <= words_out_r + 16'd1;
      end else begin
         words_out_r <= words_out_r;
      end
   end

   assign bus.fifo_rd   = pop_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_lanes = out_lanes_r;
   assign words_out     = words_out_r;

endmodule

// File: doc/i2s_pcm_packer.md
# i2s_pcm_packer

Downstream consumer of the I2S receiver's sample FIFO: pops PCM samples from the FIFO read port and packs 1×32-, 2×16- or 4×8-bit samples into 32-bit words. Packed words go out on a valid/ready stream for a DMA or bus-side buffer. Partial words are emitted on an explicit flush or after a programmable idle timeout, so low-rate audio does not stall in the packer. Sits between the I2S RX FIFO (`fifo_rd`/`fifo_rdata`/`fifo_empty`) and the system-side data path.

## Interface

Parameters:
- `TW`, 16, width of the idle-timeout counter and `timeout` port.

Ports:
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  packer enable.
- `pack_mode`  in  2  `00` 1×32, `01` 2×16, `10` 4×8, `11` treated as `00`; latched on the `en` rising edge.
- `timeout`  in  TW  idle cycles before a partial word is flushed; 0 disables the timeout.
- `flush`  in  1  single-cycle request to emit the current partial word.
- `fifo_empty`  in  1  RX FIFO empty.
- `fifo_rdata`  in  32  FIFO head entry, valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_rd`  out  1  combinational pop strobe; pops one entry in the cycle it is high.
- `out_valid`  out  1  packed word available.
- `out_ready`  in  1  consumer accepts the word when `out_valid`&`out_ready`.
- `out_data`  out  32  packed word; sample 0 in the lowest lane.
- `out_lanes`  out  3  number of valid lanes in `out_data` (1..4).
- `words_out`  out  16  count of accepted words, wraps at 0xFFFF→0.

## Operation

- Lanes per word N: 1 (mode `00`), 2 (`01`), 4 (`10`). Lane width is 32/N.
- Sample extraction: `fifo_rdata[31:0]`, `[15:0]`, or `[7:0]`. The FIFO data is already right-aligned and sign-extended upstream.
- Internal state: accumulator `acc[31:0]`, `lane_cnt` (0..N-1), `idle_ctr[TW-1:0]`, `mode_q`.
- FSM states:
  - IDLE: `en`=0. On `en` 0→1, latch `mode_q` and go to RUN.
  - RUN: packs samples. Flush trigger with `lane_cnt`>0 → DRAIN. `en`=0 → IDLE.
  - DRAIN: waits for a free output slot, then emits the partial word → RUN.
- Slot free = `out_valid`=0 or (`out_valid`&`out_ready`).
- `fifo_rd` = RUN & `en` & !`fifo_empty` & (`lane_cnt`<N-1 or slot free). The packer never pops a completing sample while the output is blocked.
- Pop, not completing: write the sample into lane `lane_cnt` of `acc`, then `lane_cnt`+1.
- Pop, completing the word: `out_data` ← `acc` with the final lane merged; `out_lanes` ← N; `out_valid` ← 1; `acc` ← 0; `lane_cnt` ← 0.
- Flush trigger: `flush` pulse, or `idle_ctr`==`timeout`≠0.
  - With `lane_cnt`=0, a trigger is ignored.
  - `flush` seen in DRAIN is absorbed.
- DRAIN emit: `out_data` ← `acc` (unused lanes 0), `out_lanes` ← `lane_cnt`, clear `acc`/`lane_cnt`. No pops occur in DRAIN.
- `idle_ctr`: cleared on every pop and whenever `lane_cnt`=0; otherwise increments in RUN and saturates at all-ones.
- `en` deasserted in any state: `acc`, `lane_cnt` and `idle_ctr` are cleared, and a partial word is discarded. A word already on `out_valid` stays asserted until accepted; it is never retracted.
- Changes to `pack_mode` while `en`=1 are ignored.
- `words_out` increments on each `out_valid`&`out_ready`, independent of `en`.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_lanes`=0, `words_out`=0, `fifo_rd`=0, state IDLE, `mode_q`=`00`.
- Latency: completing pop in cycle t → `out_valid`=1 in cycle t+1.
- Throughput: one pop per cycle while the FIFO is non-empty. With `out_ready` held high, one word per N cycles.
- Back-to-back: an accept and a new word load can occur in the same cycle. `out_valid` then stays 1 with the new data.
- Timeout: last pop in cycle t with `lane_cnt`>0 → `idle_ctr`==`timeout` at cycle t+`timeout` → partial word on `out_valid` at cycle t+`timeout`+2 when the slot is free (one cycle into DRAIN, one to emit).
- Flush in the same cycle as a completing pop: the pop wins, `lane_cnt` becomes 0, and the flush is ignored.
- Flush in the same cycle as a non-completing pop: the sample is included in the partial word.
- `out_data`/`out_lanes` are stable while `out_valid`=1 and `out_ready`=0.
- Async reset mid-operation: all state returns to reset values immediately. The FIFO contents are not touched.

## Test plan

- Mode `01`, `out_ready`=1, FIFO holds 0x1111, 0x2222, 0x3333, 0x4444 → words 0x22221111 and 0x44443333, `out_lanes`=2, `words_out`=2, four `fifo_rd` pulses on consecutive cycles.
- Mode `10`, FIFO holds 0x01,0x02,0x03, `timeout`=8, no more data → one word 0x00030201, `out_lanes`=3, asserted exactly 10 cycles after the third pop.
- Mode `00`, `out_ready`=0 for 20 cycles with 3 entries queued → exactly one pop, `out_valid` held with stable data. On release, the remaining 2 words follow at one per cycle.
- Mode `01`, one sample 0xBEEF packed, `flush` pulse → word 0x0000BEEF, `out_lanes`=1. A second `flush` with `lane_cnt`=0 → no output.
- `en` dropped after 3 of 4 lanes (mode `10`) with an unaccepted word on `out_valid` → that word remains until `out_ready`. The partial word is discarded. After `en` re-asserts, the next word starts at lane 0.
- Mode `00`, `rst_n` asserted while `out_valid`=1 → all outputs 0 in the same cycle. After reset, `words_out` wraps from 0xFFFF to 0 after 65536 accepted words.
